// File: rtl/star_tally_pkg.sv
// star_tally_pkg: shared game constants for the star collectible tally.
// FSM encoding, default blink timing (25 MHz sys_clk) and popcount.
package star_tally_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLASH = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FLASH = ST_FLASH,
        S_CLEAR = ST_CLEAR
    } star_state_e;

    localparam int MAX_STARS  = 15;
    localparam int SYS_CLK_HZ = 25_000_000;

    // 0.5 s window, 1/16 s half-period at 25 MHz
    localparam logic [23:0] FLASH_CYCLES_DEF = 24'(SYS_CLK_HZ / 2);
    localparam logic [23:0] FLASH_HALF_DEF   = 24'(SYS_CLK_HZ / 16);

    // counts set bits among the low n bits of v
    function automatic logic [3:0] popcount(
        input logic [MAX_STARS-1:0] v,
        input int                   n
    );
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < MAX_STARS; i++) begin
            if (i < n && v[i]) c = c + 4'd1;
        end
        return c;
    endfunction

endpackage

// File: rtl/star_tally_if.sv
// star_tally_if: touch/restart inputs and tally/HUD outputs of star_tally.
// master = star objects + HUD side, slave = star_tally (sfx_req if STAR_TALLY_SFX_EN).
interface star_tally_if #(
    parameter int NUM_STARS = 3,
    parameter int CNT_W     = 4
);
    logic [NUM_STARS-1:0] touch_star;
    logic                 level_restart;
    logic [NUM_STARS-1:0] star_mask;
    logic [CNT_W-1:0]     star_count;
    logic                 flash;
    logic                 level_clear;
`ifdef STAR_TALLY_SFX_EN
    logic                 sfx_req;

    modport master (
        output touch_star, level_restart,
        input  star_mask, star_count, flash, level_clear, sfx_req
    );
    modport slave (
        input  touch_star, level_restart,
        output star_mask, star_count, flash, level_clear, sfx_req
    );
`else
    modport master (
        output touch_star, level_restart,
        input  star_mask, star_count, flash, level_clear
    );
    modport slave (
        input  touch_star, level_restart,
        output star_mask, star_count, flash, level_clear
    );
`endif
endinterface

// File: rtl/star_tally_blink.sv
// star_blink_timer: blink window after a pickup; i_start (re)starts it.
// Ports: sys_clk, RST_N, i_start, i_clear -> o_flash (toggling), o_done.
module star_blink_timer
    import star_tally_pkg::*;
#(
    parameter logic [23:0] FLASH_CYCLES = FLASH_CYCLES_DEF,
    parameter logic [23:0] FLASH_HALF   = FLASH_HALF_DEF
) (
    input  logic sys_clk,
    input  logic RST_N,
    input  logic i_start,
    input  logic i_clear,
    output logic o_flash,
    output logic o_done
);

    logic [23:0] r_flash_tmr;
    logic [23:0] r_half_tmr;
    logic        r_active;
    logic        r_flash;

    // high during the last cycle of the window
    assign o_done  = r_active & (r_flash_tmr == FLASH_CYCLES - 24'd1);
    assign o_flash = r_flash;

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            r_flash_tmr <= '0;
            r_half_tmr  <= '0;
            r_active    <= 1'b0;
            r_flash     <= 1'b0;
        end else if (i_clear) begin
            r_flash_tmr <= '0;
            r_half_tmr  <= '0;
            r_active    <= 1'b0;
            r_flash     <= 1'b0;
        end else if (i_start) begin
            r_flash_tmr <= '0;
            r_half_tmr  <= '0;
            r_active    <= 1'b1;
            r_flash     <= 1'b1;
        end else if (o_done) begin
            r_flash_tmr <= '0;
            r_half_tmr  <= '0;
            r_active    <= 1'b0;
            r_flash     <= 1'b0;
        end else if (r_active) begin
            r_flash_tmr <= r_flash_tmr + 24'd1;
            if (r_half_tmr == FLASH_HALF - 24'd1) begin
                r_half_tmr <= '0;
                r_flash    <= ~r_flash;
            end else begin
                r_half_tmr <= r_half_tmr + 24'd1;
            end
        end
    end

endmodule

// File: rtl/star_tally.sv
// star_tally: collects star touch pulses into mask/count, blinks HUD, flags level clear.
// Ports: sys_clk, RST_N, bus (star_tally_if.slave). Option: STAR_TALLY_SFX_EN adds sfx_req.
module star_tally
    import star_tally_pkg::*;
#(
    parameter int          NUM_STARS    = 3,
    parameter logic [23:0] FLASH_CYCLES = FLASH_CYCLES_DEF,
    parameter logic [23:0] FLASH_HALF   = FLASH_HALF_DEF,
    parameter int          CNT_W        = 4
) (
    input  logic         sys_clk,
    input  logic         RST_N,
    star_tally_if.slave  bus
);

    logic [NUM_STARS-1:0] r_touch_s;
    logic [NUM_STARS-1:0] r_touch_q;
    logic [NUM_STARS-1:0] r_mask;
    logic [CNT_W-1:0]     r_count;
    star_state_e          r_state;
    logic                 r_level_clear;

    logic [NUM_STARS-1:0] w_new_hits;
    logic [3:0]           w_pop;
    logic [CNT_W:0]       w_sum;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_start;
    logic                 w_done;
    logic                 w_flash;

    // sample stage then edge stage: mask updates two edges after the touch
    assign w_new_hits  = r_touch_s & ~r_touch_q & ~r_mask;
    assign w_pop       = popcount(MAX_STARS'(w_new_hits), NUM_STARS);
    assign w_sum       = {1'b0, r_count} + (CNT_W+1)'(w_pop);
    assign w_count_nxt = (w_sum > (CNT_W+1)'(NUM_STARS))
                       ? CNT_W'(NUM_STARS) : w_sum[CNT_W-1:0];
    assign w_start     = (|w_new_hits) & ~bus.level_restart
                       & (r_state != S_CLEAR);

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            r_touch_s <= '0;
            r_touch_q <= '0;
            r_mask    <= '0;
            r_count   <= '0;
        end else if (bus.level_restart) begin
            // held touches are re-counted after a restart
            r_touch_s <= '0;
            r_touch_q <= '0;
            r_mask    <= '0;
            r_count   <= '0;
        end else begin
            r_touch_s <= bus.touch_star;
            r_touch_q <= r_touch_s;
            if (|w_new_hits) begin
                r_mask  <= r_mask | w_new_hits;
                r_count <= w_count_nxt;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_level_clear <= 1'b0;
        end else if (bus.level_restart) begin
            r_state       <= S_IDLE;
            r_level_clear <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) r_state <= S_FLASH;
                end
                S_FLASH: begin
                    if (!w_start && w_done) begin
                        if (r_count == CNT_W'(NUM_STARS)) begin
                            r_state       <= S_CLEAR;
                            r_level_clear <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_CLEAR: begin
                    r_level_clear <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_level_clear <= 1'b0;
                end
            endcase
        end
    end

    star_blink_timer #(
        .FLASH_CYCLES (FLASH_CYCLES),
        .FLASH_HALF   (FLASH_HALF)
    ) u_blink (
        .sys_clk (sys_clk),
        .RST_N   (RST_N),
        .i_start (w_start),
        .i_clear (bus.level_restart),
        .o_flash (w_flash),
        .o_done  (w_done)
    );

    assign bus.star_mask   = r_mask;
    assign bus.star_count  = r_count;
    assign bus.flash       = w_flash;
    assign bus.level_clear = r_level_clear;

`ifdef STAR_TALLY_SFX_EN
    logic r_sfx;
    logic r_sfx_ext;

    // the completing pickup stretches the trigger to two cycles
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            r_sfx     <= 1'b0;
            r_sfx_ext <= 1'b0;
        end else if (bus.level_restart) begin
            r_sfx     <= 1'b0;
            r_sfx_ext <= 1'b0;
        end else begin
            r_sfx     <= (|w_new_hits) | r_sfx_ext;
            r_sfx_ext <= (|w_new_hits)
                       & (w_count_nxt == CNT_W'(NUM_STARS));
        end
    end

    assign bus.sfx_req = r_sfx;
`endif

endmodule

// File: tb/tb_star_tally.sv
// tb_star_tally: vector table, directed corner sequences and random stimulus
// against a time-based behavioural model of the star tally.
module tb_star_tally;

    localparam int N  = 3;
    localparam int FC = 20;
    localparam int FH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    star_tally_if #(.NUM_STARS(N), .CNT_W(4)) bus();

    star_tally #(
        .NUM_STARS    (N),
        .FLASH_CYCLES (24'd20),
        .FLASH_HALF   (24'd4),
        .CNT_W        (4)
    ) dut (
        .sys_clk (clk),
        .RST_N   (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: collected set, last two sampled touch vectors, window age
    logic [2:0] m_mask;
    logic [2:0] m_seen;
    logic [2:0] m_seen_prev;
    int         m_age;
    logic       m_lc;

    typedef struct packed {
        logic [2:0] t;
        logic       rs;
        logic [2:0] m;
        logic [3:0] c;
        logic       f;
        logic       lc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_mask      = '0;
        m_seen      = '0;
        m_seen_prev = '0;
        m_age       = -1;
        m_lc        = 1'b0;
    endtask

    function automatic logic m_flash();
        return (m_age >= 0) && (((m_age / FH) % 2) == 0);
    endfunction

    task automatic model_step(input logic [2:0] t, input logic rs);
        logic [2:0] fresh;
        if (rs) begin
            model_clear();
            return;
        end
        fresh       = m_seen & ~m_seen_prev & ~m_mask;
        m_seen_prev = m_seen;
        m_seen      = t;
        if (fresh != 3'b000) begin
            m_mask = m_mask | fresh;
            m_age  = 0;
        end else if (m_age >= 0) begin
            m_age++;
            if (m_age == FC) begin
                m_age = -1;
                if ($countones(m_mask) == N) m_lc = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic [2:0] t, input logic rs);
        bus.touch_star    = t;
        bus.level_restart = rs;
        @(posedge clk);
        model_step(t, rs);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".mask"}, 32'(bus.star_mask), 32'(m_mask));
        chk({tag, ".count"}, 32'(bus.star_count), $countones(m_mask));
        chk({tag, ".flash"}, 32'(bus.flash), 32'(m_flash()));
        chk({tag, ".lc"}, 32'(bus.level_clear), 32'(m_lc));
    endtask

    initial begin
        int highs;
        logic prev_f;
        logic found;

        bus.touch_star    = '0;
        bus.level_restart = 1'b0;
        model_clear();

        tbl[0]  = '{3'b000, 1'b1, 3'b000, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{3'b101, 1'b0, 3'b000, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{3'b000, 1'b0, 3'b101, 4'd2, 1'b1, 1'b0};
        tbl[3]  = '{3'b000, 1'b0, 3'b101, 4'd2, 1'b1, 1'b0};
        tbl[4]  = '{3'b010, 1'b0, 3'b101, 4'd2, 1'b1, 1'b0};
        tbl[5]  = '{3'b010, 1'b0, 3'b111, 4'd3, 1'b1, 1'b0};
        tbl[6]  = '{3'b010, 1'b0, 3'b111, 4'd3, 1'b1, 1'b0};
        tbl[7]  = '{3'b000, 1'b0, 3'b111, 4'd3, 1'b1, 1'b0};
        tbl[8]  = '{3'b000, 1'b0, 3'b111, 4'd3, 1'b1, 1'b0};
        tbl[9]  = '{3'b000, 1'b0, 3'b111, 4'd3, 1'b0, 1'b0};
        tbl[10] = '{3'b111, 1'b1, 3'b000, 4'd0, 1'b0, 1'b0};
        tbl[11] = '{3'b000, 1'b0, 3'b000, 4'd0, 1'b0, 1'b0};

        #12;
        chk("reset.mask", 32'(bus.star_mask), 0);
        chk("reset.count", 32'(bus.star_count), 0);
        chk("reset.flash", 32'(bus.flash), 0);
        chk("reset.lc", 32'(bus.level_clear), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].t, tbl[i].rs);
            chk($sformatf("tbl%0d.mask", i), 32'(bus.star_mask), 32'(tbl[i].m));
            chk($sformatf("tbl%0d.count", i), 32'(bus.star_count), 32'(tbl[i].c));
            chk($sformatf("tbl%0d.flash", i), 32'(bus.flash), 32'(tbl[i].f));
            chk($sformatf("tbl%0d.lc", i), 32'(bus.level_clear), 32'(tbl[i].lc));
        end

        // single hit: 2-edge latency, 20-cycle window, 4-cycle toggles
        cyc(3'b000, 1'b1);
        cyc(3'b001, 1'b0);
        chk("single.lat1", 32'(bus.star_mask), 0);
        highs = 0;
        for (int i = 0; i < 25; i++) begin
            cyc(3'b000, 1'b0);
            chk_model($sformatf("single%0d", i));
            if (i == 0) chk("single.lat2", 32'(bus.star_count), 1);
            if (bus.flash) highs++;
        end
        chk("single.highs", highs, 12);
        chk("single.lc", 32'(bus.level_clear), 0);

        // held touch counts once, one window
        cyc(3'b000, 1'b1);
        highs = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(3'b010, 1'b0);
            chk_model($sformatf("held%0d", i));
            if (bus.flash) highs++;
        end
        for (int i = 0; i < 5; i++) cyc(3'b000, 1'b0);
        chk("held.count", 32'(bus.star_count), 1);
        chk("held.highs", highs, 12);

        // retrigger, completion, level_clear timing
        cyc(3'b000, 1'b1);
        cyc(3'b001, 1'b0);
        for (int i = 0; i < 11; i++) begin
            cyc(3'b000, 1'b0);
            chk_model($sformatf("rt_a%0d", i));
        end
        cyc(3'b010, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(3'b000, 1'b0);
            chk_model($sformatf("rt_b%0d", i));
        end
        cyc(3'b100, 1'b0);
        prev_f = bus.flash;
        found  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc(3'b000, 1'b0);
            chk_model($sformatf("rt_c%0d", i));
            if (!found && bus.level_clear) begin
                found = 1'b1;
                chk("rt.lc_prev_flash", 32'(prev_f), 1);
                chk("rt.lc_flash", 32'(bus.flash), 0);
            end
            prev_f = bus.flash;
        end
        chk("rt.lc_seen", 32'(found), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(3'b111, 1'b0);
            cyc(3'b000, 1'b0);
        end
        chk("clear.count", 32'(bus.star_count), 3);
        chk("clear.mask", 32'(bus.star_mask), 7);
        chk("clear.lc", 32'(bus.level_clear), 1);
        chk("clear.flash", 32'(bus.flash), 0);

        // restart with a simultaneous hit
        cyc(3'b010, 1'b1);
        chk("restart.mask", 32'(bus.star_mask), 0);
        chk("restart.count", 32'(bus.star_count), 0);
        chk("restart.lc", 32'(bus.level_clear), 0);
        chk("restart.flash", 32'(bus.flash), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(3'b000, 1'b0);
            chk_model($sformatf("restart%0d", i));
            chk($sformatf("restart.ign%0d", i), 32'(bus.star_mask), 0);
        end

        // async reset mid-window
        cyc(3'b100, 1'b0);
        cyc(3'b000, 1'b0);
        cyc(3'b000, 1'b0);
        chk("async.pre_flash", 32'(bus.flash), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async.mask", 32'(bus.star_mask), 0);
        chk("async.count", 32'(bus.star_count), 0);
        chk("async.flash", 32'(bus.flash), 0);
        chk("async.lc", 32'(bus.level_clear), 0);
        model_clear();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(3'b000, 1'b0);
            chk_model($sformatf("async%0d", i));
        end

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [2:0] t;
            logic       rs;
            t  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            rs = ($urandom_range(0, 79) == 0);
            cyc(t, rs);
            chk_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
